sobel_stream_core: RTL

SOBEL_STREAM_CORE -- requirements
Module: sobel_stream_core

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_line_buffer.sv | 29 ++
 rtl/sobel_stream_core.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the streaming Sobel edge core: FSM states, output modes
// and the saturating cycle-counter helper.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MAG = 1'b0,
    MODE_BIN = 1'b1
  } mode_e;

  localparam int CYCLE_W = 32;

  // Sticks at all-ones instead of wrapping.
  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage. The read is combinational so the old value
// at an address is available in the same cycle that a new one is written.
module sobel_line_buffer #(
  parameter int DEPTH  = 240,
  parameter int DATA_W = 8,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  // NOTE: storage is deliberately left without reset so it maps onto RAM;
  // rows 0 and 1 of every frame overwrite it before any output depends on it.
  // NOTE: sequential state is always written with <= so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, one |Gx|+|Gy| result
// per interior pixel out, with ready/valid back-pressure on both sides.
module sobel_stream_core
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240,
  parameter int DATA_W = 8,
  parameter int THRESH = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                done,
  output logic [CYCLE_W-1:0]  total_cycles_out
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int G_W   = DATA_W + 4;

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [DATA_W-1:0] THRESH_V = THRESH[DATA_W-1:0];

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                more_q, more_d;
  logic [CYCLE_W-1:0]  cyc_q, cyc_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  // Index 0 is the oldest row (r-2), index 2 the row being received.
  logic [DATA_W-1:0]   lft_q [3];
  logic [DATA_W-1:0]   mid_q [3];
  logic [DATA_W-1:0]   rgt   [3];

  logic [DATA_W-1:0]   prev_row, prev2_row;
  logic                accept, interior, frame_end;

  assign in_ready  = (state_q == RUN) && more_q && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign interior  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign frame_end = (row_q == LAST_ROW) && (col_q == LAST_COL);

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_last         = out_last_q;
  assign done             = (state_q == DONE);
  assign total_cycles_out = cyc_q;

  sobel_line_buffer #(.DEPTH(WIDTH), .DATA_W(DATA_W)) u_line_prev (
    .clk       (clk),
    .we_i      (accept),
    .addr_i    (col_q),
    .wr_data_i (in_data),
    .rd_data_o (prev_row)
  );

  // Cascade: the row leaving the first buffer becomes the two-rows-back row.
  sobel_line_buffer #(.DEPTH(WIDTH), .DATA_W(DATA_W)) u_line_prev2 (
    .clk       (clk),
    .we_i      (accept),
    .addr_i    (col_q),
    .wr_data_i (prev_row),
    .rd_data_o (prev2_row)
  );

  assign rgt[0] = prev2_row;
  assign rgt[1] = prev_row;
  assign rgt[2] = in_data;

  logic [G_W-1:0]        col_l, col_r, row_t, row_b;
  logic signed [G_W-1:0] gx, gy;
  logic [G_W-1:0]        abs_gx, abs_gy, mag;
  logic [DATA_W-1:0]     mag_sat, result;

  // Kernel is evaluated on the incoming column so the result lands one edge
  // after the bottom-right pixel of the window is accepted.
  always_comb begin
    col_l = G_W'(lft_q[0]) + (G_W'(lft_q[1]) << 1) + G_W'(lft_q[2]);
    col_r = G_W'(rgt[0])   + (G_W'(rgt[1])   << 1) + G_W'(rgt[2]);
    row_t = G_W'(lft_q[0]) + (G_W'(mid_q[0]) << 1) + G_W'(rgt[0]);
    row_b = G_W'(lft_q[2]) + (G_W'(mid_q[2]) << 1) + G_W'(rgt[2]);
    gx     = $signed(col_r) - $signed(col_l);
    gy     = $signed(row_b) - $signed(row_t);
    abs_gx = gx[G_W-1] ? -gx : gx;
    abs_gy = gy[G_W-1] ? -gy : gy;
    mag    = abs_gx + abs_gy;
    mag_sat = (|mag[G_W-1:DATA_W]) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    if (mode_q == MODE_BIN) begin
      result = (mag >= G_W'(THRESH_V)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    end else begin
      result = mag_sat;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (out_valid_q && out_ready && out_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    row_d       = row_q;
    col_d       = col_q;
    more_d      = more_q;
    cyc_d       = cyc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (state_q == IDLE && start) begin
      mode_d = mode_e'(mode);
      row_d  = '0;
      col_d  = '0;
      more_d = 1'b1;
      cyc_d  = CYCLE_W'(1);
    end else if (state_q == RUN) begin
      cyc_d = sat_inc(cyc_q);
    end

    if (accept) begin
      if (frame_end) begin
        more_d = 1'b0;
        row_d  = '0;
        col_d  = '0;
      end else if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // Accepting is only possible when the output slot is free or draining.
    if (accept && interior) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_last_d  = frame_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_MAG;
      row_q       <= '0;
      col_q       <= '0;
      more_q      <= 1'b0;
      cyc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      col_q       <= col_d;
      more_q      <= more_d;
      cyc_q       <= cyc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        lft_q[i] <= '0;
        mid_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        lft_q[i] <= mid_q[i];
        mid_q[i] <= rgt[i];
      end
    end
  end

endmodule
